// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the coordinate type for the VGA timing slice.
package vga_timing_pkg;
    localparam int COORD_W   = 10;
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/visible flags registered
// from the next count so they line up with the count itself.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int DISPLAY     = 640,
    parameter int FRONT       = 16,
    parameter int SYNC        = 96,
    parameter int BACK        = 48,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   enable,
    output coord_t count,
    output logic   termCount,
    output logic   syncOut,
    output logic   visible
);
    localparam int     TOTAL      = DISPLAY + FRONT + SYNC + BACK;
    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t VIS_END    = coord_t'(DISPLAY);
    localparam coord_t SYNC_FIRST = coord_t'(DISPLAY + FRONT);
    localparam coord_t SYNC_LAST  = coord_t'(DISPLAY + FRONT + SYNC - 1);

    coord_t countNext;

    assign termCount = (count == LAST);

    always_comb begin
        countNext = count;
        if (enable) countNext = termCount ? '0 : count + 1'b1;
    end

    // Reset parks on the last position so the first enable lands on 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count   <= LAST;
            syncOut <= ~SYNC_ACTIVE;
            visible <= 1'b0;
        end else begin
            count   <= countNext;
            visible <= (countNext < VIS_END);
            syncOut <= ((countNext >= SYNC_FIRST) && (countNext <= SYNC_LAST)) ?
                       SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: clock divider to pixel rate, H/V raster counters,
// sync, active-video and line/frame start pulses, all aligned to pixelX/pixelY.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_BACK      = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_BACK      = vga_timing_pkg::V_BACK,
    parameter int TICK_DIV    = 4,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic   clock,
    input  logic   reset,
    output logic   pTick,
    output logic   hSync,
    output logic   vSync,
    output logic   videoON,
    output coord_t pixelX,
    output coord_t pixelY,
    output logic   lineStart,
    output logic   frameStart
);
    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (H_TOT > 1024 || V_TOT > 1024 || TICK_DIV < 1) begin : gBadParams
        $error("vga_timing_gen: raster exceeds 1024 or TICK_DIV < 1");
    end

    logic [DIV_W-1:0] divCnt;
    logic             hTc, vTc, hVisible, vVisible;

    // With TICK_DIV=1 the divider sits at 0 and pTick is permanently high.
    assign pTick = (divCnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) divCnt <= '0;
        else        divCnt <= pTick ? '0 : divCnt + 1'b1;
    end

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
        .SYNC_ACTIVE(SYNC_ACTIVE)
    ) uHoriz (
        .clock(clock), .reset(reset), .enable(pTick),
        .count(pixelX), .termCount(hTc), .syncOut(hSync), .visible(hVisible)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
        .SYNC_ACTIVE(SYNC_ACTIVE)
    ) uVert (
        .clock(clock), .reset(reset), .enable(pTick && hTc),
        .count(pixelY), .termCount(vTc), .syncOut(vSync), .visible(vVisible)
    );

    // Both flags are registers updated on the same edge as the counters.
    assign videoON = hVisible && vVisible;

    // Pulses last only the first clock of the new pixel, not all TICK_DIV clocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            lineStart  <= pTick && hTc;
            frameStart <= pTick && hTc && vTc;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480/div-4 instance for reset, first tick, line
// timing and async reset; a tiny div-1 active-high instance for frame-level checks.
module tb_vga_timing_gen;
    logic clock = 1'b0;
    logic rstA = 1'b0;
    logic rstB = 1'b0;
    always #5 clock = ~clock;

    logic       aTick, aHs, aVs, aVid, aLs, aFs;
    logic [9:0] aX, aY;
    logic       bTick, bHs, bVs, bVid, bLs, bFs;
    logic [9:0] bX, bY;

    int nPass = 0;
    int nCheck = 0;

    vga_timing_gen uA (
        .clock(clock), .reset(rstA), .pTick(aTick), .hSync(aHs), .vSync(aVs),
        .videoON(aVid), .pixelX(aX), .pixelY(aY), .lineStart(aLs), .frameStart(aFs)
    );

    // 16x11 raster: H sync at x 10..12, V sync at y 7..8, visible 8x6.
    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
        .TICK_DIV(1), .SYNC_ACTIVE(1'b1)
    ) uB (
        .clock(clock), .reset(rstB), .pTick(bTick), .hSync(bHs), .vSync(bVs),
        .videoON(bVid), .pixelX(bX), .pixelY(bY), .lineStart(bLs), .frameStart(bFs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCheck++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    initial begin
        int hLow, vid, fsCnt, firstLowIdx, firstLowX, found;
        int tks, bHsHi, bVsHi, bVidHi, bFsCnt, bLsCnt, vsIdx, vsX;

        // ---- reset values, both instances held
        repeat (3) @(negedge clock);
        check("A rst x", aX, 799);
        check("A rst y", aY, 524);
        check("A rst vid", aVid, 0);
        check("A rst hs", aHs, 1);
        check("A rst vs", aVs, 1);
        check("A rst ls", aLs, 0);
        check("A rst fs", aFs, 0);
        check("A rst tick", aTick, 0);
        check("B rst x", bX, 15);
        check("B rst y", bY, 10);
        check("B rst hs", bHs, 0);
        check("B rst vs", bVs, 0);

        // ---- release A; first pTick in 3rd..4th clock, wrap at 4th edge
        rstA = 1'b1;
        @(negedge clock);
        check("A tick edge1", aTick, 0);
        repeat (2) @(negedge clock);
        check("A tick edge3", aTick, 1);
        check("A x edge3", aX, 799);
        @(negedge clock);
        check("A x edge4", aX, 0);
        check("A y edge4", aY, 0);
        check("A fs edge4", aFs, 1);
        check("A ls edge4", aLs, 1);
        check("A vid edge4", aVid, 1);
        check("A tick edge4", aTick, 0);

        // ---- one full line of 3200 clocks
        hLow = 0; vid = 0; fsCnt = 0; firstLowIdx = -1; firstLowX = 0;
        for (int i = 0; i < 3200; i++) begin
            if (!aHs) begin
                if (firstLowIdx < 0) begin firstLowIdx = i; firstLowX = aX; end
                hLow++;
            end
            if (aVid) vid++;
            if (aFs) fsCnt++;
            @(negedge clock);
        end
        check("A hsync low clocks", hLow, 384);
        check("A hsync fall idx", firstLowIdx, 2624);
        check("A hsync fall x", firstLowX, 656);
        check("A video clocks", vid, 2560);
        check("A fs pulses line0", fsCnt, 1);
        check("A next ls", aLs, 1);
        check("A next x", aX, 0);
        check("A next y", aY, 1);
        check("A next fs", aFs, 0);

        // ---- async reset mid-pixel at (320,1)
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            if (aX == 10'd320) found = 1;
            else @(negedge clock);
        end
        check("A reach x320", found, 1);
        @(negedge clock);
        #2 rstA = 1'b0;
        #1;
        check("A async x", aX, 799);
        check("A async y", aY, 524);
        check("A async vid", aVid, 0);
        check("A async hs", aHs, 1);
        @(negedge clock);
        rstA = 1'b1;
        repeat (3) @(negedge clock);
        check("A fs before 4th", aFs, 0);
        @(negedge clock);
        check("A fs after rst", aFs, 1);
        check("A x after rst", aX, 0);

        // ---- B: TICK_DIV=1, SYNC_ACTIVE=1, full frame = 176 clocks
        rstB = 1'b1;
        @(negedge clock);
        check("B fs edge1", bFs, 1);
        check("B x edge1", bX, 0);
        check("B vid edge1", bVid, 1);
        tks = 0; bHsHi = 0; bVsHi = 0; bVidHi = 0; bFsCnt = 0; bLsCnt = 0;
        vsIdx = -1; vsX = 0;
        for (int i = 0; i < 176; i++) begin
            if (bTick) tks++;
            if (bHs) bHsHi++;
            if (bVs) begin
                if (vsIdx < 0) begin vsIdx = i; vsX = bX; end
                bVsHi++;
            end
            if (bVid) bVidHi++;
            if (bFs) bFsCnt++;
            if (bLs) bLsCnt++;
            @(negedge clock);
        end
        check("B tick clocks", tks, 176);
        check("B hsync high", bHsHi, 33);
        check("B vsync high", bVsHi, 32);
        check("B vsync start idx", vsIdx, 112);
        check("B vsync start x", vsX, 0);
        check("B video clocks", bVidHi, 48);
        check("B fs per frame", bFsCnt, 1);
        check("B ls per frame", bLsCnt, 11);
        check("B fs period", bFs, 1);

        // ---- wrap at end of mid line: (15,3) -> (0,4)
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (bX == 10'd15 && bY == 10'd3) found = 1;
            else @(negedge clock);
        end
        check("B reach 15,3", found, 1);
        @(negedge clock);
        check("B wrap x", bX, 0);
        check("B wrap y", bY, 4);
        check("B wrap ls", bLs, 1);
        check("B wrap fs", bFs, 0);

        // ---- wrap at end of frame: (15,10) -> (0,0)
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (bX == 10'd15 && bY == 10'd10) found = 1;
            else @(negedge clock);
        end
        check("B reach 15,10", found, 1);
        @(negedge clock);
        check("B fwrap x", bX, 0);
        check("B fwrap y", bY, 0);
        check("B fwrap ls", bLs, 1);
        check("B fwrap fs", bFs, 1);

        // ---- B async reset mid-frame at (4,5)
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (bX == 10'd4 && bY == 10'd5) found = 1;
            else @(negedge clock);
        end
        check("B reach 4,5", found, 1);
        #2 rstB = 1'b0;
        #1;
        check("B async x", bX, 15);
        check("B async y", bY, 10);
        check("B async vid", bVid, 0);
        @(negedge clock);
        rstB = 1'b1;
        @(negedge clock);
        check("B fs after rst", bFs, 1);
        check("B y after rst", bY, 0);

        $display("%0d/%0d checks passed", nPass, nCheck);
        $finish;
    end
endmodule
